// File: rtl/ex_flag_branch_stage.sv
// EX/MEM stage that sits directly behind the ALU. It registers the ALU
// result into the EX/MEM pipeline register, owns the architectural N/Z/V
// flag register, resolves conditional branches against the already
// committed flags, and discards the wrong-path instructions that follow a
// taken branch.
`timescale 1ns/1ps
module ex_flag_branch_stage #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int BR_SHADOW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ex_valid,
    input  logic [5:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic              ex_n,
    input  logic              ex_z,
    input  logic              ex_v,
    input  logic              ex_is_br,
    input  logic [2:0]        ex_cond,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic [4:0]        ex_rd,
    input  logic              ex_we,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [4:0]        mem_rd,
    output logic              mem_we,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_v,
    output logic              br_taken,
    output logic [ADDR_W-1:0] br_target
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    localparam logic [2:0] SHADOW_CNT = 3'(BR_SHADOW);

    // Branch condition evaluated against the committed flag register.
    function automatic logic cond_true(input logic [2:0] cond,
                                       input logic n, input logic z, input logic v);
        logic res;
        case (cond)
            3'd0:    res = ~z;
            3'd1:    res = z;
            3'd2:    res = ~z & (n == v);
            3'd3:    res = (n != v);
            3'd4:    res = (n == v);
            3'd5:    res = z | (n != v);
            3'd6:    res = v;
            3'd7:    res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Only arithmetic/logic ops produce architectural flags; shifts, NO_OP
    // and undefined encodings leave them alone.
    function automatic logic op_sets_flags(input logic [5:0] op);
        logic res;
        case (op)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h28: res = 1'b1;
            default:                                         res = 1'b0;
        endcase
        return res;
    endfunction

    state_t              state_q;
    logic [2:0]          cnt_q;
    logic                mem_valid_q;
    logic [DATA_W-1:0]   mem_result_q;
    logic [4:0]          mem_rd_q;
    logic                mem_we_q;
    logic                flag_n_q;
    logic                flag_z_q;
    logic                flag_v_q;
    logic                br_taken_q;
    logic [ADDR_W-1:0]   br_target_q;

    logic                accept_s;
    logic                take_s;
    logic                flag_wr_s;

    // Decode which action the EX instruction takes on the coming edge.
    always_comb begin
        accept_s  = ex_valid & ~stall_i & ~flush_i & (state_q == ST_RUN);
        take_s    = accept_s & ex_is_br & cond_true(ex_cond, flag_n_q, flag_z_q, flag_v_q);
        flag_wr_s = accept_s & ~ex_is_br & op_sets_flags(ex_opcode);
    end

    // Pipeline register, flag register and squash FSM; flush beats stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            cnt_q        <= 3'd0;
            mem_valid_q  <= 1'b0;
            mem_result_q <= {DATA_W{1'b0}};
            mem_rd_q     <= 5'd0;
            mem_we_q     <= 1'b0;
            flag_n_q     <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_v_q     <= 1'b0;
            br_taken_q   <= 1'b0;
            br_target_q  <= {ADDR_W{1'b0}};
        end else if (flush_i) begin
            state_q     <= ST_RUN;
            cnt_q       <= 3'd0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            br_taken_q  <= 1'b0;
        end else if (stall_i) begin
            // Everything holds; only the branch pulse is dropped.
            br_taken_q <= 1'b0;
        end else begin
            br_taken_q <= take_s;
            if (take_s) begin
                br_target_q <= ex_target;
            end else begin
                br_target_q <= br_target_q;
            end

            if (accept_s && !ex_is_br) begin
                mem_valid_q  <= 1'b1;
                mem_result_q <= ex_alu_out;
                mem_rd_q     <= ex_rd;
                mem_we_q     <= ex_we;
            end else begin
                mem_valid_q <= 1'b0;
                mem_we_q    <= 1'b0;
            end

            if (flag_wr_s) begin
                flag_n_q <= ex_n;
                flag_z_q <= ex_z;
                flag_v_q <= ex_v;
            end else begin
                flag_n_q <= flag_n_q;
            end

            case (state_q)
                ST_RUN: begin
                    if (take_s) begin
                        state_q <= ST_SQUASH;
                        cnt_q   <= SHADOW_CNT;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_SQUASH: begin
                    // Each valid wrong-path instruction burns one shadow slot.
                    if (ex_valid) begin
                        if (cnt_q <= 3'd1) begin
                            state_q <= ST_RUN;
                            cnt_q   <= 3'd0;
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_result = mem_result_q;
    assign mem_rd     = mem_rd_q;
    assign mem_we     = mem_we_q;
    assign flag_n     = flag_n_q;
    assign flag_z     = flag_z_q;
    assign flag_v     = flag_v_q;
    assign br_taken   = br_taken_q;
    assign br_target  = br_target_q;

endmodule

// File: tb/tb_ex_flag_branch_stage.sv
// Directed bench for ex_flag_branch_stage: the driver issues one EX slot per
// cycle and queues the hand-computed post-edge outputs; a monitor thread pops
// and compares them one time unit after each rising edge.
`timescale 1ns/1ps
module tb_ex_flag_branch_stage;

    typedef struct packed {
        logic        mv;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  nzv;
        logic        bt;
        logic [31:0] tgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, ex_valid;
    logic [5:0]  ex_opcode;
    logic [31:0] ex_alu_out;
    logic        ex_n, ex_z, ex_v, ex_is_br;
    logic [2:0]  ex_cond;
    logic [31:0] ex_target;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        mem_valid, mem_we, flag_n, flag_z, flag_v, br_taken;
    logic [31:0] mem_result, br_target;
    logic [4:0]  mem_rd;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    ex_flag_branch_stage #(.DATA_W(32), .ADDR_W(32), .BR_SHADOW(2)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out),
        .ex_n(ex_n), .ex_z(ex_z), .ex_v(ex_v), .ex_is_br(ex_is_br),
        .ex_cond(ex_cond), .ex_target(ex_target), .ex_rd(ex_rd), .ex_we(ex_we),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
        .mem_we(mem_we), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
        .br_taken(br_taken), .br_target(br_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t E(input logic mv, input logic [31:0] res, input logic [4:0] rd,
                               input logic we, input logic [2:0] nzv, input logic bt,
                               input logic [31:0] tgt);
        exp_t e;
        e.mv = mv; e.res = res; e.rd = rd; e.we = we; e.nzv = nzv; e.bt = bt; e.tgt = tgt;
        return e;
    endfunction

    // One EX slot: drive at the falling edge, queue what must show after the rise.
    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] res,
                         input logic [2:0] nzv, input logic br, input logic [2:0] cond,
                         input logic [31:0] tgt, input logic [4:0] rd, input logic we,
                         input logic st, input logic fl, input exp_t e);
        @(negedge clk);
        ex_valid = v; ex_opcode = op; ex_alu_out = res;
        {ex_n, ex_z, ex_v} = nzv; ex_is_br = br; ex_cond = cond; ex_target = tgt;
        ex_rd = rd; ex_we = we; stall_i = st; flush_i = fl;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
        chk({tag, "_mem_result"}, mem_result, 32'd0);
        chk({tag, "_mem_rd"}, {27'd0, mem_rd}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_flags"}, {29'd0, flag_n, flag_z, flag_v}, 32'd0);
        chk({tag, "_br_taken"}, {31'd0, br_taken}, 32'd0);
        chk({tag, "_br_target"}, br_target, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; ex_valid = 1'b0; ex_opcode = 6'd0;
        ex_alu_out = 32'd0; ex_n = 1'b0; ex_z = 1'b0; ex_v = 1'b0; ex_is_br = 1'b0;
        ex_cond = 3'd0; ex_target = 32'd0; ex_rd = 5'd0; ex_we = 1'b0;

        fork
            // Monitor: pop one expectation per rising edge when one is pending.
            forever begin
                exp_t e;
                @(posedge clk);
                #1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("mem_valid", {31'd0, mem_valid}, {31'd0, e.mv});
                    chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                    chk("flags_nzv", {29'd0, flag_n, flag_z, flag_v}, {29'd0, e.nzv});
                    chk("br_taken", {31'd0, br_taken}, {31'd0, e.bt});
                    if (e.mv) begin
                        chk("mem_result", mem_result, e.res);
                        chk("mem_rd", {27'd0, mem_rd}, {27'd0, e.rd});
                    end
                    if (e.bt) begin
                        chk("br_target", br_target, e.tgt);
                    end
                end
            end
            // Watchdog so the run always ends.
            begin
                repeat (2000) @(posedge clk);
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // ADD result 0 sets Z; SLL must not touch flags.
        drive(1'b1, 6'h20, 32'h0,        3'b010, 1'b0, 3'd0, 32'h0,  5'd1,  1'b1, 1'b0, 1'b0, E(1'b1, 32'h0,        5'd1, 1'b1, 3'b010, 1'b0, 32'h0));
        drive(1'b1, 6'h27, 32'h10,       3'b000, 1'b0, 3'd0, 32'h0,  5'd2,  1'b1, 1'b0, 1'b0, E(1'b1, 32'h10,       5'd2, 1'b1, 3'b010, 1'b0, 32'h0));
        // SUB gives N=1,V=0; GE not taken, LT taken to 0x40.
        drive(1'b1, 6'h22, 32'hFFFFFFFF, 3'b100, 1'b0, 3'd0, 32'h0,  5'd3,  1'b1, 1'b0, 1'b0, E(1'b1, 32'hFFFFFFFF, 5'd3, 1'b1, 3'b100, 1'b0, 32'h0));
        drive(1'b1, 6'h30, 32'h0,        3'b000, 1'b1, 3'd4, 32'h50, 5'd0,  1'b1, 1'b0, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b100, 1'b0, 32'h0));
        drive(1'b1, 6'h30, 32'h0,        3'b000, 1'b1, 3'd3, 32'h40, 5'd0,  1'b1, 1'b0, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b100, 1'b1, 32'h40));
        // Two shadow instructions discarded, the third commits.
        drive(1'b1, 6'h20, 32'h5,        3'b000, 1'b0, 3'd0, 32'h0,  5'd4,  1'b1, 1'b0, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b100, 1'b0, 32'h0));
        drive(1'b1, 6'h28, 32'h6,        3'b010, 1'b0, 3'd0, 32'h0,  5'd5,  1'b1, 1'b0, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b100, 1'b0, 32'h0));
        drive(1'b1, 6'h24, 32'h7,        3'b000, 1'b0, 3'd0, 32'h0,  5'd6,  1'b1, 1'b0, 1'b0, E(1'b1, 32'h7,        5'd6, 1'b1, 3'b000, 1'b0, 32'h0));
        // Three stall cycles with ADD in EX, then it commits once.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'h20, 32'h9,    3'b001, 1'b0, 3'd0, 32'h0,  5'd7,  1'b1, 1'b1, 1'b0, E(1'b1, 32'h7,        5'd6, 1'b1, 3'b000, 1'b0, 32'h0));
        end
        drive(1'b1, 6'h20, 32'h9,        3'b001, 1'b0, 3'd0, 32'h0,  5'd7,  1'b1, 1'b0, 1'b0, E(1'b1, 32'h9,        5'd7, 1'b1, 3'b001, 1'b0, 32'h0));
        drive(1'b0, 6'h00, 32'h0,        3'b000, 1'b0, 3'd0, 32'h0,  5'd0,  1'b0, 1'b0, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b001, 1'b0, 32'h0));
        // ALWAYS branch; idle and stall in SQUASH hold the count; flush returns to RUN.
        drive(1'b1, 6'h30, 32'h0,        3'b000, 1'b1, 3'd7, 32'h80, 5'd0,  1'b0, 1'b0, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b001, 1'b1, 32'h80));
        drive(1'b0, 6'h00, 32'h0,        3'b000, 1'b0, 3'd0, 32'h0,  5'd0,  1'b0, 1'b0, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b001, 1'b0, 32'h0));
        drive(1'b1, 6'h20, 32'h15,       3'b100, 1'b0, 3'd0, 32'h0,  5'd13, 1'b1, 1'b0, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b001, 1'b0, 32'h0));
        drive(1'b1, 6'h20, 32'h15,       3'b100, 1'b0, 3'd0, 32'h0,  5'd13, 1'b1, 1'b1, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b001, 1'b0, 32'h0));
        drive(1'b1, 6'h20, 32'h15,       3'b110, 1'b0, 3'd0, 32'h0,  5'd13, 1'b1, 1'b0, 1'b1, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b001, 1'b0, 32'h0));
        drive(1'b1, 6'h21, 32'h11,       3'b110, 1'b0, 3'd0, 32'h0,  5'd8,  1'b1, 1'b0, 1'b0, E(1'b1, 32'h11,       5'd8, 1'b1, 3'b110, 1'b0, 32'h0));
        // Flush kills an ADD in RUN; NO_OP and an undefined op leave flags alone.
        drive(1'b1, 6'h20, 32'h12,       3'b010, 1'b0, 3'd0, 32'h0,  5'd9,  1'b1, 1'b0, 1'b1, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b110, 1'b0, 32'h0));
        drive(1'b1, 6'h3F, 32'h22,       3'b111, 1'b0, 3'd0, 32'h0,  5'd10, 1'b1, 1'b0, 1'b0, E(1'b1, 32'h22,       5'd10, 1'b1, 3'b110, 1'b0, 32'h0));
        drive(1'b1, 6'h01, 32'h33,       3'b001, 1'b0, 3'd0, 32'h0,  5'd11, 1'b0, 1'b0, 1'b0, E(1'b1, 32'h33,       5'd11, 1'b0, 3'b110, 1'b0, 32'h0));
        // EQ with Z=1 taken, one shadow consumed, then async reset mid-SQUASH.
        drive(1'b1, 6'h30, 32'h0,        3'b000, 1'b1, 3'd1, 32'h100, 5'd0, 1'b0, 1'b0, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b110, 1'b1, 32'h100));
        drive(1'b1, 6'h20, 32'h55,       3'b000, 1'b0, 3'd0, 32'h0,  5'd14, 1'b1, 1'b0, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b110, 1'b0, 32'h0));
        @(negedge clk);
        ex_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        // Back in RUN: ADD commits, GT on cleared flags is taken.
        drive(1'b1, 6'h20, 32'h44,       3'b000, 1'b0, 3'd0, 32'h0,  5'd12, 1'b1, 1'b0, 1'b0, E(1'b1, 32'h44,       5'd12, 1'b1, 3'b000, 1'b0, 32'h0));
        drive(1'b1, 6'h30, 32'h0,        3'b000, 1'b1, 3'd2, 32'h200, 5'd0, 1'b0, 1'b0, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b000, 1'b1, 32'h200));
        drive(1'b0, 6'h00, 32'h0,        3'b000, 1'b0, 3'd0, 32'h0,  5'd0,  1'b0, 1'b0, 1'b0, E(1'b0, 32'h0,        5'd0, 1'b0, 3'b000, 1'b0, 32'h0));

        @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
